// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one 8N1 transmitter among NREQ byte producers.
// Optional macro UART_ARB_LOCK_EN keeps the grant on one requester until its req_last byte.
module uart_tx_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy,
  output logic              uart_we,
  output logic [7:0]        uart_data,
  input  logic              uart_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic [IDW-1:0]  r_gnt_id, w_gnt_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_uart_we, w_we_nxt;
  logic [7:0]      r_uart_data, w_data_nxt;
  logic [IDW-1:0]  r_rr_ptr, w_rr_nxt;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_rot;
  logic            w_found;
  logic [IDW-1:0]  w_ofs;
  logic [IDW:0]    w_sum;
  logic [IDW:0]    w_wrap;
  logic [IDW-1:0]  w_winner;
  logic [IDW-1:0]  w_rr_adv;
  logic [7:0]      w_win_data;
  logic            w_grant;
  logic            w_rr_step;
  logic            w_lock_nxt;

`ifdef UART_ARB_LOCK_EN
  logic           r_lock;
  logic [IDW-1:0] r_lock_id, w_lock_id_nxt;
  logic           w_win_last;

  // While a message is open only its owner may be granted.
  assign w_elig = r_lock ? (req & (NREQ'(1) << r_lock_id)) : req;

  always_comb begin
    w_win_last = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) == w_winner) w_win_last = req_last[j];
    end
  end

  always_comb begin
    w_lock_nxt    = r_lock;
    w_lock_id_nxt = r_lock_id;
    if (w_grant) begin
      w_lock_nxt    = ~w_win_last;
      w_lock_id_nxt = w_winner;
    end
  end

  assign w_rr_step = w_win_last;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else begin
      r_lock    <= w_lock_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end
`else
  logic w_unused_last;
  assign w_elig        = req;
  assign w_lock_nxt    = 1'b0;
  assign w_rr_step     = 1'b1;
  assign w_unused_last = ^req_last;
`endif

  // Rotate so bit 0 is the requester at rr_ptr; the first set bit is the winner offset.
  assign w_rot = NREQ'({w_elig, w_elig} >> r_rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_ofs   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_ofs   = IDW'(k);
      end
    end
  end

  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_ofs};
  assign w_wrap   = w_sum - (IDW+1)'(NREQ);
  assign w_winner = (w_sum >= (IDW+1)'(NREQ)) ? w_wrap[IDW-1:0] : w_sum[IDW-1:0];
  assign w_rr_adv = (w_winner == IDW'(NREQ-1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_win_data = 8'h00;
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) == w_winner) w_win_data = req_data[8*j +: 8];
    end
  end

  assign w_grant = (r_state == IDLE) && uart_ready && w_found;

  // NOTE: non-blocking assignments in clocked processes so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: each combinational process assigns a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = SEND;
      SEND:    w_state_nxt = WAIT;
      WAIT:    if (uart_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt  = '0;
    w_we_nxt   = 1'b0;
    w_data_nxt = r_uart_data;
    w_gnt_nxt  = r_gnt_id;
    w_rr_nxt   = r_rr_ptr;
    if (w_grant) begin
      w_ack_nxt  = NREQ'(1) << w_winner;
      w_we_nxt   = 1'b1;
      w_data_nxt = w_win_data;
      w_gnt_nxt  = w_winner;
      if (w_rr_step) w_rr_nxt = w_rr_adv;
    end
    w_busy_nxt = (w_state_nxt != IDLE) || w_lock_nxt;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_ack       <= '0;
      r_gnt_id    <= '0;
      r_busy      <= 1'b0;
      r_uart_we   <= 1'b0;
      r_uart_data <= 8'h00;
      r_rr_ptr    <= '0;
    end else begin
      r_ack       <= w_ack_nxt;
      r_gnt_id    <= w_gnt_nxt;
      r_busy      <= w_busy_nxt;
      r_uart_we   <= w_we_nxt;
      r_uart_data <= w_data_nxt;
      r_rr_ptr    <= w_rr_nxt;
    end
  end

  assign ack       = r_ack;
  assign gnt_id    = r_gnt_id;
  assign busy      = r_busy;
  assign uart_we   = r_uart_we;
  assign uart_data = r_uart_data;

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares one 8N1 serial transmitter between NREQ byte producers, e.g. debug/status sources in the ethaudio path.
- Each requester offers one byte with a req/ack handshake.
- The block sequences the transmitter's we/data/ready interface so that only one byte is ever in flight.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 3, width of gnt_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock.
- rst_  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester byte-valid; held high until ack.
- req_data  input  8*NREQ  byte for requester i at bits [8i+7:8i]; stable while req[i]=1.
- req_last  input  NREQ  last byte of a message; used only with UART_ARB_LOCK_EN.
- ack  output  NREQ  one-cycle pulse; the byte of requester i was handed to the transmitter.
- gnt_id  output  IDW  index of the most recently granted requester.
- busy  output  1  arbiter not idle, or a lock is held.
- uart_we  output  1  write strobe to the transmitter.
- uart_data  output  8  byte to the transmitter.
- uart_ready  input  1  transmitter idle; falls the cycle after an accepted we and rises when the stop bit completes.

Behaviour:
- Reset values: ack=0, gnt_id=0, busy=0, uart_we=0, uart_data=8'h00, state=IDLE, rr_ptr=0, lock=0.
- Clock and reset: one clock; reset is asynchronous and active-low on rst_. Assertion returns everything to the reset state immediately, including mid-byte. The transmitter shares rst_, so no stale handshake remains.
- All outputs are registered.

States IDLE, SEND, WAIT:
- IDLE, with uart_ready=1 and an eligible req:
  - Winner is the first set req at index rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Registered for the next cycle: uart_we=1, uart_data=req_data[winner], ack[winner]=1, gnt_id=winner.
  - rr_ptr <= (winner+1) mod NREQ.
  - Next state is SEND.
- IDLE, otherwise: stay in IDLE. Nothing is issued while uart_ready=0.
- SEND: uart_we and ack are high for exactly this one cycle. Next cycle both return to 0; next state is WAIT.
- WAIT:
  - uart_ready is 0 on entry.
  - Stay until uart_ready=1, then go to IDLE.
  - If uart_ready is still 1 on the first WAIT cycle, the transmitter did not accept the byte. This is a protocol error; the bench flags it.
- Latency: req rising in IDLE with the transmitter idle gives uart_we and ack 1 cycle later.
- Spacing: consecutive uart_we pulses are at least the transmitter byte time plus 2 cycles apart.
- Requester contract:
  - After seeing ack, the requester either drops req or presents the next byte by the following edge.
  - req is not resampled before IDLE.
- Simultaneous requests: exactly one ack per grant. Requests that lose stay pending; they are never lost or reordered per requester.
- Single requester: it is granted every byte; rr_ptr still advances each grant.
- Wrap-around: granting index NREQ-1 sets rr_ptr=0.
- busy = (state != IDLE) | lock.
- uart_data holds its last value after SEND.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- With the macro defined:
  - A grant to requester i with req_last[i]=0 sets lock=1 and locks the grant to i.
  - While locked, IDLE considers only req[i]; other requests wait.
  - A granted byte with req_last[i]=1 clears lock.
  - rr_ptr advances only when lock clears, so a message is sent contiguously.
  - If the locked requester drops req, the arbiter waits indefinitely with busy=1. There is no timeout.
- Without the macro: req_last is ignored, lock is constant 0, and every byte is arbitrated independently.

Test Plan:
- Reset check: rst_ low mid-WAIT, then released → all outputs at their reset values, state=IDLE, next grant goes to index 0.
- Single request: req=4'b0100, data[23:16]=8'h5A, uart_ready=1 → one cycle later uart_we=1, uart_data=8'h5A, ack=4'b0100, gnt_id=2. No second we until uart_ready falls and rises again.
- Fairness: req=4'b1111 held for 8 bytes → grant order 0,1,2,3,0,1,2,3. Exactly one ack per uart_we.
- Back-pressure: uart_ready held 0 with req=4'b0001 → no uart_we and no ack. Release uart_ready → we within 1 cycle.
- Wrap and skip: rr_ptr=3, req=4'b0011 → grant 0 then 1.
- UART_ARB_LOCK_EN: req0 bytes A(last=0), B(last=0), C(last=1) with req1 also pending → sent sequence A,B,C, then req1's byte. Without the macro → A, req1 byte, B, C.
